// File: rtl/booth_mult_n.sv
// booth_mult_n: sequential radix-2 Booth multiplier for signed or unsigned N-bit operands.
// Optional feature macro BOOTH_RESTART_EN: start_mul during RUN aborts and reloads the operation.
module booth_mult_n #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_mul,
  input  logic           sgn,
  input  logic [N-1:0]   M_mult,
  input  logic [N-1:0]   Q_mult,
  output logic [2*N-1:0] Result_mul,
  output logic           fin,
  output logic           busy
);

  localparam int CW = $clog2(N + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N+1:0]   a_q, a_d;
  logic [N+1:0]   m_q, m_d;
  logic [N:0]     q_q, q_d;
  logic           qm1_q, qm1_d;
  logic           sgn_q, sgn_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] result_q, result_d;
  logic           fin_q, fin_d;
  logic           busy_q, busy_d;

  logic [N+1:0]   a_sum;
  logic [N+1:0]   a_shift;
  logic [N:0]     q_shift;
  logic           qm1_shift;
  logic [2*N-1:0] product;
  logic           load;

  // One Booth recoding step followed by the arithmetic right shift of {A, Q, q(-1)}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    {a_shift, q_shift, qm1_shift} = {a_sum[N+1], a_sum, q_q};
  end

  // Signed mode runs one step fewer, so its product sits one bit higher in {A, Q}.
  assign product = sgn_q ? {a_q[N-1:0], q_q[N:1]} : {a_q[N-2:0], q_q};

`ifdef BOOTH_RESTART_EN
  assign load = start_mul && (state_q == IDLE || state_q == RUN);
`else
  assign load = start_mul && (state_q == IDLE);
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (load) begin
      state_d = RUN;
      sgn_d   = sgn;
      m_d     = sgn ? {{2{M_mult[N-1]}}, M_mult} : {2'b00, M_mult};
      a_d     = '0;
      q_d     = {sgn & Q_mult[N-1], Q_mult};
      qm1_d   = 1'b0;
      cnt_d   = sgn ? CW'(N) : CW'(N + 1);
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = product;
          end else begin
            a_d   = a_shift;
            q_d   = q_shift;
            qm1_d = qm1_shift;
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end
    fin_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fin_q    <= fin_d;
      busy_q   <= busy_d;
    end
  end

  assign Result_mul = result_q;
  assign fin        = fin_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_booth_mult_n.sv
// tb_booth_mult_n: directed and random checks of booth_mult_n at N=3 and N=8 with a result scoreboard.
module tb_booth_mult_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start3, sgn3, fin3, busy3;
  logic [2:0]  m3, q3;
  logic [5:0]  res3;
  logic        start8, sgn8, fin8, busy8;
  logic [7:0]  m8, q8;
  logic [15:0] res8;

  booth_mult_n #(.N(3)) u_dut3 (
    .clk(clk), .reset(reset), .start_mul(start3), .sgn(sgn3),
    .M_mult(m3), .Q_mult(q3), .Result_mul(res3), .fin(fin3), .busy(busy3)
  );

  booth_mult_n #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start_mul(start8), .sgn(sgn8),
    .M_mult(m8), .Q_mult(q8), .Result_mul(res8), .fin(fin8), .busy(busy8)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          fin_cnt3 = 0;
  int          fin_cnt8 = 0;

  always @(posedge clk) begin
    if (fin3) fin_cnt3++;
    if (fin8) fin_cnt8++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input int n, input bit s,
                                           input logic [7:0] m, input logic [7:0] q);
    longint a, b, mask;
    mask = (longint'(1) << n) - 1;
    a = longint'(m) & mask;
    b = longint'(q) & mask;
    if (s) begin
      if (((a >> (n - 1)) & 1) == 1) a = a - (longint'(1) << n);
      if (((b >> (n - 1)) & 1) == 1) b = b - (longint'(1) << n);
    end
    return 64'((a * b) & ((longint'(1) << (2 * n)) - 1));
  endfunction

  function automatic logic fin_of(input bit w);
    return w ? fin8 : fin3;
  endfunction

  function automatic logic busy_of(input bit w);
    return w ? busy8 : busy3;
  endfunction

  function automatic logic [63:0] res_of(input bit w);
    return w ? 64'(res8) : 64'(res3);
  endfunction

  task automatic drive(input bit w, input bit st, input bit s, input logic [7:0] m, input logic [7:0] q);
    if (w) begin
      start8 = st; sgn8 = s; m8 = m; q8 = q;
    end else begin
      start3 = st; sgn3 = s; m3 = m[2:0]; q3 = q[2:0];
    end
  endtask

  // Waits for fin, checking busy on every cycle before it; lat counts edges waited.
  task automatic wait_fin(input bit w, input int budget, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      lat++;
      if (fin_of(w)) begin
        seen = 1'b1;
        break;
      end
      check("busy_run", busy_of(w), 1'b1);
    end
  endtask

  task automatic finish_op(input bit w, input string tag, input int lat, input int exp_lat, input bit seen);
    logic [63:0] exp;
    check({tag, "_fin_seen"}, seen, 1'b1);
    exp = exp_q.pop_front();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, res_of(w), exp);
    check({tag, "_busy_done"}, busy_of(w), 1'b1);
  endtask

  // poke_done holds start_mul high through DONE, which must be ignored.
  task automatic do_op(input bit w, input string tag, input bit s,
                       input logic [7:0] m, input logic [7:0] q, input bit poke_done);
    int          n, lat;
    bit          seen;
    logic [63:0] exp;
    n   = w ? 8 : 3;
    exp = ref_prod(n, s, m, q);
    @(negedge clk);
    drive(w, 1'b1, s, m, q);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    drive(w, 1'b0, ~s, 8'($urandom), 8'($urandom));
    wait_fin(w, 40, lat, seen);
    finish_op(w, tag, lat, s ? n + 1 : n + 2, seen);
    if (poke_done) begin
      @(negedge clk);
      drive(w, 1'b1, 1'b0, 8'd1, 8'd1);
    end
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 8'd0, 8'd0);
    check({tag, "_fin_one_cycle"}, fin_of(w), 1'b0);
    check({tag, "_busy_idle"}, busy_of(w), 1'b0);
    if (poke_done) begin
      @(posedge clk); #1;
      check({tag, "_done_start_ignored"}, busy_of(w), 1'b0);
      check({tag, "_result_held"}, res_of(w), exp);
    end
  endtask

  initial begin
    int  lat, f3, f8;
    bit  seen;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res3", res3, 6'd0);
    check("rst_fin3", fin3, 1'b0);
    check("rst_busy3", busy3, 1'b0);
    check("rst_res8", res8, 16'd0);
    check("rst_busy8", busy8, 1'b0);
    reset = 1'b0;

    do_op(1'b0, "signed_m3x3", 1'b1, 8'b101, 8'b011, 1'b0);
    check("signed_m3x3_const", res3, 6'b110111);
    do_op(1'b0, "unsigned_5x3", 1'b0, 8'b101, 8'b011, 1'b0);
    check("unsigned_5x3_const", res3, 6'b001111);

    // Reset lands on the second RUN edge of a fresh operation.
    f3 = fin_cnt3;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'd3, 8'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'd3, 8'd3);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_run_busy", busy3, 1'b0);
    check("rst_run_fin", fin3, 1'b0);
    check("rst_run_res", res3, 6'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_run_no_fin", fin_cnt3 - f3, 0);

    do_op(1'b0, "signed_min", 1'b1, 8'b100, 8'b100, 1'b1);
    check("signed_min_const", res3, 6'b010000);
    do_op(1'b1, "n8_signed_80", 1'b1, 8'h80, 8'h80, 1'b0);
    check("n8_signed_80_const", res8, 16'h4000);
    do_op(1'b1, "n8_unsigned_ff", 1'b0, 8'hFF, 8'hFF, 1'b1);
    check("n8_unsigned_ff_const", res8, 16'hFE01);

    // start_mul with 2*2 during RUN of an unsigned 3*3.
    f3 = fin_cnt3;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'd3, 8'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
`ifdef BOOTH_RESTART_EN
    exp_q.push_back(64'd4);
    wait_fin(1'b0, 40, lat, seen);
    finish_op(1'b0, "restart", lat, 5, seen);
`else
    exp_q.push_back(64'd9);
    wait_fin(1'b0, 40, lat, seen);
    finish_op(1'b0, "restart", lat, 3, seen);
`endif
    repeat (12) @(posedge clk);
    #1;
    check("restart_single_fin", fin_cnt3 - f3, 1);
    check("restart_idle", busy3, 1'b0);

    f3 = fin_cnt3;
    f8 = fin_cnt8;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, "rand3", 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 1'b0);
      do_op(1'b1, "rand8", 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end
    check("rand3_fin_count", fin_cnt3 - f3, 8);
    check("rand8_fin_count", fin_cnt8 - f8, 8);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
